// File: rtl/integrate.sv
`default_nettype none
// ============================================================================
//  Module   : integrate
//  Purpose  : Cascaded N-stage CIC integrator section with valid/ready stream
//             ports. One output sample per accepted input sample; m_dat is
//             the last-stage accumulator, with no extra output register.
//  Options  : INTEGRATE_SAT_EN - when defined, each stage addition saturates
//             to the signed W-bit range instead of wrapping modulo 2^W.
//             Leave undefined for CIC use (wrap is cancelled by the comb).
//  Revision : 1.0 - initial release
// ============================================================================
module integrate #(
  parameter int W = 32,  // data / accumulator width, two's complement
  parameter int N = 1    // number of integrator stages, 1..8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] s_dat,
  input  logic         s_val,
  output logic         s_rdy,
  output logic [W-1:0] m_dat,
  output logic         m_val,
  input  logic         m_rdy
);

  localparam logic [W-1:0] C_SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] C_SMIN = {1'b1, {(W-1){1'b0}}};

  // Stage k of the chain is held in acc_q[k-1]; acc_q[N-1] is the output.
  logic [W-1:0] acc_q [N];
  logic [W-1:0] acc_d [N];
  logic         m_val_q;
  logic         m_val_d;
  logic         w_in_xfer;
  logic         w_out_xfer;

  // One stage addition: modulo 2^W by default, signed saturation when the
  // option is built in (overflow only when both operands share a sign that
  // the result does not).
  function automatic logic [W-1:0] stage_add(input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [W-1:0] sum;
    sum = a + b;
`ifdef INTEGRATE_SAT_EN
    if ((a[W-1] == b[W-1]) && (sum[W-1] != a[W-1])) begin
      sum = a[W-1] ? C_SMIN : C_SMAX;
    end
`endif
    return sum;
  endfunction

  // Ready only depends on the output side, so an occupied-but-draining
  // output slot still allows a new sample in the same cycle.
  assign s_rdy      = !m_val_q || m_rdy;
  assign w_in_xfer  = s_val && s_rdy;
  assign w_out_xfer = m_val_q && m_rdy;
  assign m_val      = m_val_q;
  assign m_dat      = acc_q[N-1];

  // Next-state: all stages advance together from pre-edge values on an
  // input transfer; otherwise accumulators hold and only the valid flag
  // may clear when the pending output is taken.
  always_comb begin
    acc_d   = acc_q;
    m_val_d = m_val_q;
    if (w_in_xfer) begin
      acc_d[0] = stage_add(acc_q[0], s_dat);
      for (int k = 1; k < N; k++) begin
        acc_d[k] = stage_add(acc_q[k], acc_q[k-1]);
      end
      m_val_d = 1'b1;
    end else if (w_out_xfer) begin
      m_val_d = 1'b0;
    end
  end

  // State registers; reset discards all partial sums and any pending output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        acc_q[k] <= '0;
      end
      m_val_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      m_val_q <= m_val_d;
    end
  end

endmodule
`default_nettype wire
